// File: rtl/sync_fifo_buf.sv
// rtl/sync_fifo_buf.sv - single-clock FIFO with registered/show-ahead read, thresholds and sticky errors
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   wr_en/wdata  write request and data
//   rd_en        read request (pop of the displayed word in show-ahead mode)
//   rdata/rvalid read data and its valid qualifier
//   full/empty   occupancy == FIFO_LENGTH / == 0
//   almost_full  count >= AF_LEVEL
//   almost_empty count <= AE_LEVEL
//   count        occupancy, 0..FIFO_LENGTH
//   overflow     sticky, a write was rejected
//   underflow    sticky, a read was rejected
//   clr_err      synchronous clear of overflow/underflow (a coincident set wins)

module sync_fifo_buf #(
  parameter int DATA_WIDTH  = 4,
  parameter int FIFO_LENGTH = 128,
  parameter int READ_REG    = 1,
  parameter int AF_LEVEL    = FIFO_LENGTH - 2,
  parameter int AE_LEVEL    = 2,
  localparam int ADDR_W     = $clog2(FIFO_LENGTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_W:0]       count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam logic [ADDR_W:0] AF_TH = (ADDR_W + 1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_TH = (ADDR_W + 1)'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [FIFO_LENGTH];

  // One extra MSB on each pointer distinguishes full from empty when the
  // low (address) bits coincide.
  logic [ADDR_W:0] wptr;
  logic [ADDR_W:0] rptr;
  logic            rd_acc;
  logic            wr_acc;

  assign empty = (wptr == rptr);
  assign full  = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                 (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);

  // Modulo subtraction of the wide pointers gives occupancy directly,
  // including across the wrap.
  assign count        = wptr - rptr;
  assign almost_full  = (count >= AF_TH);
  assign almost_empty = (count <= AE_TH);

  // A write into a full FIFO is still taken when a read frees the head slot
  // on the same edge; the slot being written is the one being read, and the
  // read sees the old word because both use non-blocking updates.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) rptr <= rptr + 1'b1;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr[ADDR_W-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow  & ~clr_err) | (wr_en & ~wr_acc);
      underflow <= (underflow & ~clr_err) | (rd_en & ~rd_acc);
    end
  end

  generate
    if (READ_REG != 0) begin : g_reg_read
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rdata  <= '0;
          rvalid <= 1'b0;
        end else begin
          rvalid <= rd_acc;
          if (rd_acc) rdata <= mem[rptr[ADDR_W-1:0]];
        end
      end
    end else begin : g_show_ahead
      // Head word is presented continuously; rd_en acknowledges it.
      assign rdata  = mem[rptr[ADDR_W-1:0]];
      assign rvalid = ~empty;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_buf.sv
// tb/tb_sync_fifo_buf.sv - randomized self-checking bench for sync_fifo_buf against a queue model

module tb_sync_fifo_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Registered-read instance
  logic       we1, re1, ce1;
  logic [3:0] wd1, rdata1, count1;
  logic       rvalid1, full1, empty1, af1, ae1, ov1, uf1;

  // Show-ahead instance
  logic       we0, re0, ce0;
  logic [3:0] wd0, rdata0, count0;
  logic       rvalid0, full0, empty0, af0, ae0, ov0, uf0;

  sync_fifo_buf #(.DATA_WIDTH(4), .FIFO_LENGTH(8), .READ_REG(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(we1), .wdata(wd1), .rd_en(re1),
    .rdata(rdata1), .rvalid(rvalid1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(count1),
    .overflow(ov1), .underflow(uf1), .clr_err(ce1)
  );

  sync_fifo_buf #(.DATA_WIDTH(4), .FIFO_LENGTH(8), .READ_REG(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(we0), .wdata(wd0), .rd_en(re0),
    .rdata(rdata0), .rvalid(rvalid0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(count0),
    .overflow(ov0), .underflow(uf0), .clr_err(ce0)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: plain queues of stored words plus sticky bits.
  logic [3:0] q1[$];
  logic [3:0] m1_rdata;
  logic       m1_rvalid, m1_ov, m1_uf;
  logic [3:0] q0[$];
  logic       m0_ov, m0_uf;

  task automatic model_reset();
    q1.delete();
    q0.delete();
    m1_rdata  = 4'h0;
    m1_rvalid = 1'b0;
    m1_ov = 1'b0; m1_uf = 1'b0;
    m0_ov = 1'b0; m0_uf = 1'b0;
  endtask

  // One clock on the registered-read instance; model updated at the edge.
  task automatic step1(input logic we, input logic [3:0] wd, input logic re, input logic ce);
    bit racc, wacc;
    we1 = we; wd1 = wd; re1 = re; ce1 = ce;
    racc = re && (q1.size() != 0);
    wacc = we && ((q1.size() != 8) || racc);
    @(posedge clk);
    if (racc) begin
      m1_rdata  = q1.pop_front();
      m1_rvalid = 1'b1;
    end else begin
      m1_rvalid = 1'b0;
    end
    if (wacc) q1.push_back(wd);
    m1_ov = (m1_ov && !ce) || (we && !wacc);
    m1_uf = (m1_uf && !ce) || (re && !racc);
    #1;
    we1 = 1'b0; re1 = 1'b0; ce1 = 1'b0;
  endtask

  // One clock on the show-ahead instance.
  task automatic step0(input logic we, input logic [3:0] wd, input logic re, input logic ce);
    bit racc, wacc;
    we0 = we; wd0 = wd; re0 = re; ce0 = ce;
    racc = re && (q0.size() != 0);
    wacc = we && ((q0.size() != 8) || racc);
    @(posedge clk);
    if (racc) void'(q0.pop_front());
    if (wacc) q0.push_back(wd);
    m0_ov = (m0_ov && !ce) || (we && !wacc);
    m0_uf = (m0_uf && !ce) || (re && !racc);
    #1;
    we0 = 1'b0; re0 = 1'b0; ce0 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    we1 = 0; re1 = 0; ce1 = 0; wd1 = 0;
    we0 = 0; re0 = 0; ce0 = 0; wd0 = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (int'(count1) !== 0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count1); end
    checks++; if (empty1 !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty1); end
    checks++; if (ae1 !== 1'b1) begin errors++; $display("FAIL reset_almost_empty: got %b expected 1", ae1); end
    checks++; if (full1 !== 1'b0 || af1 !== 1'b0) begin errors++; $display("FAIL reset_full_af: got %b%b expected 00", full1, af1); end
    checks++; if (rvalid1 !== 1'b0 || rdata1 !== 4'h0) begin errors++; $display("FAIL reset_read: got rvalid %b rdata %h expected 0 0", rvalid1, rdata1); end
    checks++; if (ov1 !== 1'b0 || uf1 !== 1'b0) begin errors++; $display("FAIL reset_err: got %b%b expected 00", ov1, uf1); end
    checks++; if (empty0 !== 1'b1 || rvalid0 !== 1'b0 || int'(count0) !== 0) begin errors++; $display("FAIL reset_sa: got empty %b rvalid %b count %0d expected 1 0 0", empty0, rvalid0, count0); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 8; i++) begin
      step1(1'b1, 4'(i), 1'b0, 1'b0);
      checks++; if (int'(count1) !== q1.size()) begin errors++; $display("FAIL fill_count: got %0d expected %0d", count1, q1.size()); end
      checks++; if (af1 !== (q1.size() >= 6)) begin errors++; $display("FAIL fill_af: got %b at count %0d", af1, q1.size()); end
      checks++; if (full1 !== (q1.size() == 8)) begin errors++; $display("FAIL fill_full: got %b at count %0d", full1, q1.size()); end
      checks++; if (ae1 !== (q1.size() <= 2)) begin errors++; $display("FAIL fill_ae: got %b at count %0d", ae1, q1.size()); end
    end
    step1(1'b1, 4'hF, 1'b0, 1'b0);
    checks++; if (ov1 !== m1_ov || ov1 !== 1'b1) begin errors++; $display("FAIL overflow_set: got %b expected 1", ov1); end
    checks++; if (int'(count1) !== 8) begin errors++; $display("FAIL overflow_count: got %0d expected 8", count1); end
    step1(1'b0, 4'h0, 1'b0, 1'b1);
    checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL overflow_clear: got %b expected 0", ov1); end
    for (int i = 1; i <= 8; i++) begin
      step1(1'b0, 4'h0, 1'b1, 1'b0);
      checks++; if (rvalid1 !== 1'b1) begin errors++; $display("FAIL drain_rvalid: got %b expected 1", rvalid1); end
      checks++; if (rdata1 !== m1_rdata) begin errors++; $display("FAIL drain_rdata: got %h expected %h", rdata1, m1_rdata); end
    end
    step1(1'b0, 4'h0, 1'b0, 1'b0);
    checks++; if (rvalid1 !== 1'b0 || rdata1 !== m1_rdata) begin errors++; $display("FAIL drain_hold: got rvalid %b rdata %h expected 0 %h", rvalid1, rdata1, m1_rdata); end
    checks++; if (empty1 !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b expected 1", empty1); end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 8; i++) step1(1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step1(1'b1, 4'hA, 1'b1, 1'b0);
      checks++; if (int'(count1) !== 8 || full1 !== 1'b1) begin errors++; $display("FAIL fullrw_count: got %0d full %b expected 8 1", count1, full1); end
      checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL fullrw_overflow: got %b expected 0", ov1); end
      checks++; if (rvalid1 !== 1'b1 || rdata1 !== m1_rdata) begin errors++; $display("FAIL fullrw_rdata: got %b %h expected 1 %h", rvalid1, rdata1, m1_rdata); end
    end
    for (int i = 0; i < 8; i++) begin
      step1(1'b0, 4'h0, 1'b1, 1'b0);
      checks++; if (rdata1 !== m1_rdata || rdata1 !== 4'hA) begin errors++; $display("FAIL fullrw_tail: got %h expected %h", rdata1, m1_rdata); end
    end
  endtask

  task automatic test_empty_errors();
    step1(1'b0, 4'h0, 1'b1, 1'b0);
    checks++; if (uf1 !== 1'b1 || rvalid1 !== 1'b0 || int'(count1) !== 0) begin errors++; $display("FAIL underflow_set: got uf %b rvalid %b count %0d expected 1 0 0", uf1, rvalid1, count1); end
    step1(1'b1, 4'h5, 1'b1, 1'b0);
    checks++; if (int'(count1) !== 1 || rvalid1 !== 1'b0) begin errors++; $display("FAIL empty_rw: got count %0d rvalid %b expected 1 0", count1, rvalid1); end
    step1(1'b0, 4'h0, 1'b1, 1'b0);
    checks++; if (rdata1 !== 4'h5 || rvalid1 !== 1'b1) begin errors++; $display("FAIL empty_rw_read: got %h %b expected 5 1", rdata1, rvalid1); end
    step1(1'b0, 4'h0, 1'b1, 1'b1);
    checks++; if (uf1 !== m1_uf || uf1 !== 1'b1) begin errors++; $display("FAIL clr_vs_set: got %b expected 1", uf1); end
    step1(1'b0, 4'h0, 1'b0, 1'b1);
    checks++; if (uf1 !== 1'b0 || ov1 !== 1'b0) begin errors++; $display("FAIL clr_alone: got uf %b ov %b expected 0 0", uf1, ov1); end
  endtask

  task automatic test_show_ahead();
    step0(1'b1, 4'h3, 1'b0, 1'b0);
    checks++; if (rvalid0 !== 1'b1 || rdata0 !== 4'h3) begin errors++; $display("FAIL sa_first: got %b %h expected 1 3", rvalid0, rdata0); end
    step0(1'b0, 4'h0, 1'b1, 1'b0);
    checks++; if (empty0 !== 1'b1 || rvalid0 !== 1'b0) begin errors++; $display("FAIL sa_pop: got empty %b rvalid %b expected 1 0", empty0, rvalid0); end
    for (int i = 0; i < 20; i++) begin
      step0(1'b1, 4'($urandom_range(0, 15)), (i >= 2), 1'b0);
      checks++; if (int'(count0) !== q0.size() || rvalid0 !== (q0.size() != 0)) begin errors++; $display("FAIL sa_wrap_count: got %0d %b expected %0d", count0, rvalid0, q0.size()); end
      if (q0.size() != 0) begin
        checks++; if (rdata0 !== q0[0]) begin errors++; $display("FAIL sa_wrap_data: got %h expected %h", rdata0, q0[0]); end
      end
    end
    while (q0.size() != 0) begin
      step0(1'b0, 4'h0, 1'b1, 1'b0);
      if (q0.size() != 0) begin
        checks++; if (rdata0 !== q0[0]) begin errors++; $display("FAIL sa_drain_data: got %h expected %h", rdata0, q0[0]); end
      end
    end
    checks++; if (empty0 !== 1'b1 || uf0 !== m0_uf || ov0 !== m0_ov) begin errors++; $display("FAIL sa_end: got empty %b uf %b ov %b", empty0, uf0, ov0); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic we, re, ce;
      // Alternate write-heavy and read-heavy phases so both full and empty are hit.
      if ((i / 50) % 2 == 0) begin
        we = ($urandom_range(0, 99) < 75); re = ($urandom_range(0, 99) < 35);
      end else begin
        we = ($urandom_range(0, 99) < 35); re = ($urandom_range(0, 99) < 75);
      end
      ce = ($urandom_range(0, 99) < 5);
      step1(we, 4'($urandom_range(0, 15)), re, ce);
      checks++; if (int'(count1) !== q1.size()) begin errors++; $display("FAIL rnd_count: got %0d expected %0d", count1, q1.size()); end
      checks++; if (empty1 !== (q1.size() == 0) || full1 !== (q1.size() == 8)) begin errors++; $display("FAIL rnd_flags: got empty %b full %b at %0d", empty1, full1, q1.size()); end
      checks++; if (af1 !== (q1.size() >= 6) || ae1 !== (q1.size() <= 2)) begin errors++; $display("FAIL rnd_almost: got af %b ae %b at %0d", af1, ae1, q1.size()); end
      checks++; if (rvalid1 !== m1_rvalid || rdata1 !== m1_rdata) begin errors++; $display("FAIL rnd_read: got %b %h expected %b %h", rvalid1, rdata1, m1_rvalid, m1_rdata); end
      checks++; if (ov1 !== m1_ov || uf1 !== m1_uf) begin errors++; $display("FAIL rnd_err: got ov %b uf %b expected %b %b", ov1, uf1, m1_ov, m1_uf); end
    end
  endtask

  task automatic test_async_reset();
    while (q1.size() != 0) step1(1'b0, 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step1(1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
    step1(1'b0, 4'h0, 1'b1, 1'b0);
    step1(1'b1, 4'h9, 1'b0, 1'b0);
    checks++; if (int'(count1) !== 5) begin errors++; $display("FAIL prereset_count: got %0d expected 5", count1); end
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    checks++; if (int'(count1) !== 0 || empty1 !== 1'b1 || full1 !== 1'b0) begin errors++; $display("FAIL async_flags: got count %0d empty %b full %b expected 0 1 0", count1, empty1, full1); end
    checks++; if (rvalid1 !== 1'b0 || rdata1 !== 4'h0 || ov1 !== 1'b0 || uf1 !== 1'b0) begin errors++; $display("FAIL async_outs: got rvalid %b rdata %h ov %b uf %b", rvalid1, rdata1, ov1, uf1); end
    checks++; if (ae1 !== 1'b1 || af1 !== 1'b0) begin errors++; $display("FAIL async_almost: got ae %b af %b expected 1 0", ae1, af1); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    step1(1'b1, 4'h7, 1'b0, 1'b0);
    checks++; if (int'(count1) !== 1) begin errors++; $display("FAIL post_reset_write: got %0d expected 1", count1); end
    step1(1'b0, 4'h0, 1'b1, 1'b0);
    checks++; if (rdata1 !== 4'h7 || rvalid1 !== 1'b1 || empty1 !== 1'b1) begin errors++; $display("FAIL post_reset_read: got %h %b empty %b expected 7 1 1", rdata1, rvalid1, empty1); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_rw();
    test_empty_errors();
    test_show_ahead();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_buf.md
Name: sync_fifo_buf

Overview:
- Single-clock FIFO buffer that wraps a parametrised memory array with its own pointer, flag and occupancy logic.
- Generalises the team's plain FIFO storage array into a self-contained queue: selectable registered or show-ahead read, programmable almost-full/almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags.
- Used as the same-domain buffer stage in front of and behind the CDC paths.

Parameters:
- DATA_WIDTH, 4, width of each stored word.
- FIFO_LENGTH, 128, depth in words; must be a power of two, >= 4. ADDR_W = log2(FIFO_LENGTH).
- READ_REG, 1, 1 = registered read (data one cycle after accept); 0 = show-ahead (head word visible combinationally).
- AF_LEVEL, FIFO_LENGTH-2, almost_full asserted when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_en  in  1  write request.
- wdata  in  DATA_WIDTH  write data.
- rd_en  in  1  read request.
- rdata  out  DATA_WIDTH  read data.
- rvalid  out  1  rdata is valid.
- full  out  1  FIFO holds FIFO_LENGTH words.
- empty  out  1  FIFO holds 0 words.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  ADDR_W+1  current occupancy, 0..FIFO_LENGTH.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.
- clr_err  in  1  synchronous clear of overflow/underflow.

Behaviour:
- Reset (rst=0, asynchronous):
  - Write and read pointers, count, overflow, underflow, rvalid (READ_REG=1) and rdata (READ_REG=1) all go to 0.
  - empty=1, full=0, almost_empty=1, almost_full=0.
  - Memory contents are not reset.
  - Reset asserted mid-operation discards all queued data. The first access after deassertion behaves as on an empty FIFO.
- Pointers:
  - ADDR_W+1 bit binary; low ADDR_W bits address memory, MSB is the wrap bit.
  - empty when pointers are equal.
  - full when MSBs differ and low bits are equal.
  - count = wptr - rptr, modulo 2^(ADDR_W+1).
  - Wrap from FIFO_LENGTH-1 to 0 is seamless.
- Accept rules, evaluated on the current-cycle flags:
  - rd_acc = rd_en & ~empty.
  - wr_acc = wr_en & (~full | rd_acc).
  - When full, a write with a simultaneous accepted read is accepted. The read returns the old word and the write stores into the freed slot on the same edge; count stays FIFO_LENGTH.
  - When empty, a simultaneous read is rejected; the write is accepted and count becomes 1.
  - Accepted write: mem[wptr] <= wdata, wptr += 1.
  - Accepted read: rptr += 1.
- count and flags:
  - count updates +1 / -1 / 0 on the edge following the accepts.
  - Flags are decoded from the registered pointers, so they are valid in the cycle after the edge.
  - almost_* follow count, and are pure comparisons of count.
- READ_REG=1:
  - On rd_acc, rdata <= mem[rptr] at the edge and rvalid=1 for one cycle.
  - Otherwise rvalid=0 and rdata holds its last value.
  - Read latency is 1 cycle.
- READ_REG=0:
  - rdata = mem[rptr low bits] combinationally and rvalid = ~empty.
  - rd_en acts as a pop/acknowledge of the displayed word.
- Write-to-read latency: a word written into an empty FIFO at edge N gives empty=0 after edge N.
  - It is readable at edge N+1.
  - READ_REG=0: visible on rdata after edge N.
- Error flags:
  - overflow sets on wr_en & ~wr_acc.
  - underflow sets on rd_en & ~rd_acc.
  - Both hold until clr_err=1 at a clock edge; if set and clear coincide, set wins.
  - Rejected accesses change no other state.

Test Plan:
- Reset then idle, FIFO_LENGTH=8, READ_REG=1 -> count=0, empty=1, almost_empty=1, full=0, rvalid=0, rdata=0.
- Write 8 words 0x1..0x8, then a 9th (0xF) -> full=1, count=8, almost_full=1 from count 6. 9th write rejected, overflow=1. Read 8 -> rdata 0x1..0x8 in order, each one cycle after rd_en with rvalid pulses; empty=1.
- Full FIFO, wr_en=rd_en=1 with wdata=0xA for 8 cycles -> count stays 8, no overflow, rdata streams the old words, then 0xA words are read out next.
- Empty FIFO, rd_en=1 alone -> underflow=1, rvalid=0, pointers unchanged. Then wr_en=rd_en=1 with 0x5 -> write only, count=1. Then clr_err together with a new bad read -> underflow stays 1; clr_err alone -> 0.
- READ_REG=0: write 0x3 -> rdata=0x3, rvalid=1 the cycle after. Pop -> empty=1, rvalid=0. Run 20 writes/reads to cross the pointer wrap twice -> data order preserved.
- Assert rst mid-stream with count=5 -> all outputs at reset values immediately (asynchronous). After release, a write of 0x7 then a read returns 0x7.
